// File: rtl/msrv32_wb_arbiter.sv
// rtl/msrv32_wb_arbiter.sv - register-file write-port arbiter between pipeline write-back and a multi-cycle unit
// One-entry result buffer with a bounded-wait force that stalls the pipeline for a single cycle.
module msrv32_wb_arbiter #(
  parameter int XLEN     = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic            ms_riscv32_mp_clk_in,
  input  logic            ms_riscv32_mp_rst_in,
  input  logic            flush_in,
  input  logic            pipe_wr_en_in,
  input  logic [4:0]      pipe_rd_addr_in,
  input  logic [XLEN-1:0] pipe_rd_data_in,
  input  logic            mc_req_in,
  input  logic [4:0]      mc_rd_addr_in,
  input  logic [XLEN-1:0] mc_rd_data_in,
  output logic            mc_ack_out,
  output logic            stall_out,
  output logic            rf_wr_en_out,
  output logic [4:0]      rf_wr_addr_out,
  output logic [XLEN-1:0] rf_wr_data_out
);

  localparam int CW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_HOLD  = 2'd1,
    S_FORCE = 2'd2
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [4:0]      r_buf_addr, w_buf_addr_nxt;
  logic [XLEN-1:0] r_buf_data, w_buf_data_nxt;
  logic [CW-1:0]   r_wait_cnt, w_wait_cnt_nxt;

  logic w_pipe_eff;
  logic w_sel_buf;
  logic w_sel_pipe;
  logic w_drop;
  logic w_blocked;
  logic w_ack;
  logic w_load;

  assign stall_out = (r_state == S_FORCE);

  assign w_pipe_eff = pipe_wr_en_in & ~flush_in & (pipe_rd_addr_in != 5'd0) & ~stall_out;
  assign w_sel_buf  = (r_state == S_FORCE) | ((r_state == S_HOLD) & ~w_pipe_eff);
  assign w_sel_pipe = w_pipe_eff;
  // A younger pipeline write to the same register makes the buffered result dead.
  assign w_drop     = (r_state == S_HOLD) & w_pipe_eff & (pipe_rd_addr_in == r_buf_addr);
  assign w_blocked  = (r_state == S_HOLD) & w_pipe_eff & ~w_drop;
  assign w_ack      = mc_req_in & ms_riscv32_mp_rst_in &
                      ((r_state == S_EMPTY) | w_sel_buf | w_drop);
  assign w_load     = w_ack & (mc_rd_addr_in != 5'd0);
  assign mc_ack_out = w_ack;

  always_comb begin
    w_state_nxt    = r_state;
    w_buf_addr_nxt = r_buf_addr;
    w_buf_data_nxt = r_buf_data;
    w_wait_cnt_nxt = r_wait_cnt;
    if (w_load) begin
      w_state_nxt    = S_HOLD;
      w_buf_addr_nxt = mc_rd_addr_in;
      w_buf_data_nxt = mc_rd_data_in;
      w_wait_cnt_nxt = '0;
    end else if (w_sel_buf | w_drop) begin
      w_state_nxt    = S_EMPTY;
      w_wait_cnt_nxt = '0;
    end else if (w_blocked) begin
      if (r_wait_cnt == CW'(MAX_WAIT - 1)) begin
        w_state_nxt    = S_FORCE;
        w_wait_cnt_nxt = '0;
      end else begin
        w_wait_cnt_nxt = r_wait_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_in) begin
    if (!ms_riscv32_mp_rst_in) begin
      r_state    <= S_EMPTY;
      r_buf_addr <= '0;
      r_buf_data <= '0;
      r_wait_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_buf_addr <= w_buf_addr_nxt;
      r_buf_data <= w_buf_data_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
    end
  end

  // Address/data hold their last value on idle cycles; only the enable drops.
  always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_in) begin
    if (!ms_riscv32_mp_rst_in) begin
      rf_wr_en_out   <= 1'b0;
      rf_wr_addr_out <= '0;
      rf_wr_data_out <= '0;
    end else begin
      rf_wr_en_out <= w_sel_buf | w_sel_pipe;
      if (w_sel_buf) begin
        rf_wr_addr_out <= r_buf_addr;
        rf_wr_data_out <= r_buf_data;
      end else if (w_sel_pipe) begin
        rf_wr_addr_out <= pipe_rd_addr_in;
        rf_wr_data_out <= pipe_rd_data_in;
      end
    end
  end

endmodule

// File: tb/tb_msrv32_wb_arbiter.sv
// tb/tb_msrv32_wb_arbiter.sv - directed self-checking bench for msrv32_wb_arbiter
module tb_msrv32_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        pipe_en;
  logic [4:0]  pipe_addr;
  logic [31:0] pipe_data;
  logic        mc_req;
  logic [4:0]  mc_addr;
  logic [31:0] mc_data;
  logic        mc_ack;
  logic        stall;
  logic        rf_en;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  msrv32_wb_arbiter #(.XLEN(32), .MAX_WAIT(4)) dut (
    .ms_riscv32_mp_clk_in (clk),
    .ms_riscv32_mp_rst_in (rst_n),
    .flush_in             (flush),
    .pipe_wr_en_in        (pipe_en),
    .pipe_rd_addr_in      (pipe_addr),
    .pipe_rd_data_in      (pipe_data),
    .mc_req_in            (mc_req),
    .mc_rd_addr_in        (mc_addr),
    .mc_rd_data_in        (mc_data),
    .mc_ack_out           (mc_ack),
    .stall_out            (stall),
    .rf_wr_en_out         (rf_en),
    .rf_wr_addr_out       (rf_addr),
    .rf_wr_data_out       (rf_data)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_wr(input string tag, input logic [4:0] a, input logic [31:0] d);
    chk({tag, "_en"}, 32'(rf_en), 32'd1);
    chk({tag, "_addr"}, 32'(rf_addr), 32'(a));
    chk({tag, "_data"}, rf_data, d);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; pipe_en = 1'b0; pipe_addr = '0; pipe_data = '0;
    mc_req = 1'b0; mc_addr = '0; mc_data = '0;

    // reset then idle
    tick(); tick();
    chk("rst_en", 32'(rf_en), 32'd0);
    chk("rst_addr", 32'(rf_addr), 32'd0);
    chk("rst_data", rf_data, 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_ack", 32'(mc_ack), 32'd0);
    rst_n = 1'b1;
    tick(); tick();
    chk("idle_en", 32'(rf_en), 32'd0);
    chk("idle_stall", 32'(stall), 32'd0);

    // pipe only
    pipe_en = 1'b1; pipe_addr = 5'd5; pipe_data = 32'hDEADBEEF;
    tick();
    chk_wr("pipe", 5'd5, 32'hDEADBEEF);

    // flushed pipe write
    flush = 1'b1; pipe_data = 32'h11111111;
    tick();
    chk("flush_en", 32'(rf_en), 32'd0);
    chk("flush_hold_data", rf_data, 32'hDEADBEEF);
    flush = 1'b0;

    // write to x0
    pipe_addr = 5'd0;
    tick();
    chk("x0_en", 32'(rf_en), 32'd0);
    pipe_en = 1'b0;

    // mc with free port
    mc_req = 1'b1; mc_addr = 5'd7; mc_data = 32'h1234;
    #1 chk("mc_ack", 32'(mc_ack), 32'd1);
    tick();
    mc_req = 1'b0;
    #1 chk("mc_ack_low", 32'(mc_ack), 32'd0);
    chk("mc_lat1_en", 32'(rf_en), 32'd0);
    tick();
    chk_wr("mc_x7", 5'd7, 32'h1234);
    tick();
    chk("mc_after_en", 32'(rf_en), 32'd0);

    // mc with addr 0: acked and discarded
    mc_req = 1'b1; mc_addr = 5'd0; mc_data = 32'hFFFF;
    #1 chk("mc0_ack", 32'(mc_ack), 32'd1);
    tick();
    mc_req = 1'b0;
    tick();
    chk("mc0_en", 32'(rf_en), 32'd0);

    // starvation force
    mc_req = 1'b1; mc_addr = 5'd7; mc_data = 32'h1234;
    tick();
    mc_req = 1'b0;
    pipe_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      pipe_addr = 5'(10 + i); pipe_data = 32'h100 + 32'(i);
      tick();
      chk_wr("starve_pipe", 5'(10 + i), 32'h100 + 32'(i));
      chk("starve_stall", 32'(stall), (i == 3) ? 32'd1 : 32'd0);
    end
    pipe_addr = 5'd14; pipe_data = 32'h114;
    #1 chk("force_nack", 32'(mc_ack), 32'd0);
    tick();
    chk_wr("force_x7", 5'd7, 32'h1234);
    chk("force_stall_end", 32'(stall), 32'd0);
    tick();
    chk_wr("force_replay", 5'd14, 32'h114);
    pipe_en = 1'b0;
    tick();
    chk("force_idle_en", 32'(rf_en), 32'd0);

    // same-address drop
    mc_req = 1'b1; mc_addr = 5'd9; mc_data = 32'hAAAA;
    tick();
    mc_req = 1'b0;
    pipe_en = 1'b1; pipe_addr = 5'd9; pipe_data = 32'hBBBB;
    tick();
    chk_wr("drop_pipe", 5'd9, 32'hBBBB);
    pipe_en = 1'b0;
    tick();
    chk("drop_en1", 32'(rf_en), 32'd0);
    tick();
    chk("drop_en2", 32'(rf_en), 32'd0);
    chk("drop_data", rf_data, 32'hBBBB);

    // flush during a would-be blocked HOLD drains the buffer
    mc_req = 1'b1; mc_addr = 5'd8; mc_data = 32'h8888;
    tick();
    mc_req = 1'b0;
    pipe_en = 1'b1; flush = 1'b1; pipe_addr = 5'd20; pipe_data = 32'h2020;
    tick();
    chk_wr("flush_drain", 5'd8, 32'h8888);
    pipe_en = 1'b0; flush = 1'b0;

    // back-to-back mc
    mc_req = 1'b1; mc_addr = 5'd3; mc_data = 32'h3333;
    #1 chk("b2b_ack3", 32'(mc_ack), 32'd1);
    tick();
    mc_addr = 5'd4; mc_data = 32'h4444;
    #1 chk("b2b_ack4", 32'(mc_ack), 32'd1);
    tick();
    mc_req = 1'b0;
    chk_wr("b2b_x3", 5'd3, 32'h3333);
    tick();
    chk_wr("b2b_x4", 5'd4, 32'h4444);
    tick();
    chk("b2b_idle", 32'(rf_en), 32'd0);

    // async reset discards buffered x4
    mc_req = 1'b1; mc_addr = 5'd4; mc_data = 32'h5555;
    tick();
    mc_req = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk("arst_en", 32'(rf_en), 32'd0);
    chk("arst_data", rf_data, 32'd0);
    mc_req = 1'b1; mc_addr = 5'd0;
    #1 chk("arst_ack_req", 32'(mc_ack), 32'd0);
    mc_req = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("arst_no_x4", 32'(rf_en), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/msrv32_wb_arbiter.md
# msrv32_wb_arbiter

Shares the single integer register-file write port between the in-order pipeline write-back and one long-latency unit (multi-cycle load/divide). Sits between the write-enable generator and the integer register file. Pipeline writes win by default. A one-entry buffer holds the multi-cycle result until the port is free. A bounded-wait counter forces the buffered result through by stalling the pipeline for one cycle.

## Interface
- XLEN, 32, register data width
- MAX_WAIT, 4, blocked cycles tolerated before buffer is forced (≥1)

- ms_riscv32_mp_clk_in, input, 1, clock, rising edge
- ms_riscv32_mp_rst_in, input, 1, reset; asynchronous, active-low
- flush_in, input, 1, squash current pipeline write
- pipe_wr_en_in, input, 1, pipeline write request (output of write-enable generator)
- pipe_rd_addr_in, input, 5, pipeline destination register
- pipe_rd_data_in, input, XLEN, pipeline write data
- mc_req_in, input, 1, multi-cycle result valid
- mc_rd_addr_in, input, 5, multi-cycle destination
- mc_rd_data_in, input, XLEN, multi-cycle result
- mc_ack_out, output, 1, result accepted this cycle (combinational)
- stall_out, output, 1, pipeline must hold its write (Moore, from state)
- rf_wr_en_out, output, 1, register-file write enable (registered)
- rf_wr_addr_out, output, 5, register-file write address (registered)
- rf_wr_data_out, output, XLEN, register-file write data (registered)

## Operation
- pipe_eff = pipe_wr_en_in & ~flush_in & (pipe_rd_addr_in != 0) & ~stall_out.
- While stall_out=1, the pipeline write is ignored. Upstream must present it again next cycle.
- Buffer state is buf_valid, buf_addr, buf_data, plus wait_cnt.
- The FSM state is derived: EMPTY (buf_valid=0), HOLD (buf_valid=1, not forced), FORCE.
- Write-port selection each cycle, in priority order:
  1. FORCE: write buffer entry.
  2. pipe_eff: write pipeline data.
  3. HOLD: write buffer entry.
  4. Otherwise no write.
- Buffer drains when it is selected (cases 1 and 3).
- Same-address drop: in HOLD, if pipe_eff and pipe_rd_addr_in == buf_addr, the buffer entry is discarded.
  - Reason: the pipeline write is younger.
  - Next state is EMPTY, unless a new mc request is accepted in the same cycle.
- mc_ack_out = mc_req_in & (buffer empty | buffer draining | buffer dropped this cycle).
  - On ack, the entry loads into the buffer at the clock edge.
  - A request with mc_rd_addr_in == 0 is acked and discarded; the buffer is not loaded.
- The mc unit holds its request until acked.
- wait_cnt:
  - Cleared on any buffer load, drain or drop.
  - Incremented in HOLD when pipe_eff blocks the buffer.
- HOLD→FORCE when a blocked cycle occurs with wait_cnt == MAX_WAIT-1.
- FORCE always lasts exactly one cycle. It then goes to EMPTY, or to HOLD if a new entry is loaded in that cycle.
- EMPTY→HOLD on an accepted nonzero mc request.
- flush_in never affects the buffer: a buffered result belongs to a committed instruction.

## Timing
- Reset (asynchronous, ms_riscv32_mp_rst_in=0) clears:
  - rf_wr_en_out, rf_wr_addr_out, rf_wr_data_out, stall_out
  - buf_valid, wait_cnt
  - State goes to EMPTY.
- mc_ack_out is 0 whenever mc_req_in=0 (including during reset).
- Reset asserted mid-operation discards the buffer entry.
- Latency:
  - Pipeline write appears on rf_wr_* 1 cycle after pipe_eff.
  - A multi-cycle result appears at least 2 cycles after ack: 1 cycle in the buffer, then the registered output.
- With no requests, rf_wr_en_out=0 and data/address hold their last values.
- Worst-case buffer wait is MAX_WAIT blocked cycles plus 1 forced cycle.
- Exactly one stall_out cycle occurs per force.
- Simultaneous events:
  - Drain and new ack in the same cycle: the new entry loads and wait_cnt restarts at 0.
  - Flush in the same cycle as a blocked HOLD: the pipeline write is squashed, so the buffer drains and no count increment occurs.

## Test plan
- Reset then idle:
  - Stimulus: rst low for 2 cycles, then high, no requests.
  - Required response: all outputs 0; rf_wr_en_out stays 0.
- Pipe-only:
  - Stimulus: pipe_wr_en=1, addr=5, data=0xDEADBEEF.
  - Required response: next cycle rf_wr_en=1, addr=5, data=0xDEADBEEF.
- Pipe write with flush:
  - Stimulus: same write with flush=1.
  - Required response: rf_wr_en=0.
- Pipe write to x0:
  - Stimulus: same write with addr=0.
  - Required response: rf_wr_en=0.
- MC with free port:
  - Stimulus: mc_req, addr=7, data=0x1234.
  - Required response: ack the same cycle; rf write to x7 two cycles later; the following cycle rf_wr_en=0.
- Starvation force (MAX_WAIT=4):
  - Stimulus: buffer holds x7=0x1234; pipeline writes distinct addresses continuously.
  - Required response: 4 pipeline writes pass; then stall_out=1 for one cycle and rf writes x7=0x1234; the pipeline write presented during the stall is written on the next cycle.
- Same-address drop:
  - Stimulus: buffer holds x9=0xAAAA; pipe writes x9=0xBBBB.
  - Required response: rf writes x9=0xBBBB; buffer empties; 0xAAAA is never written.
- Back-to-back mc plus async reset:
  - Stimulus: mc requests x3 then x4 on consecutive cycles with an idle pipe.
  - Required response: x4 is acked in the drain cycle of x3; writes to x3 then x4 on consecutive cycles.
  - Stimulus: assert reset while x4 is buffered.
  - Required response: the x4 write never occurs.
